// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_debounce_pkg.sv
// Shared definitions for the synchronising debounce filter: the state
// naming used by checkers, default parameter values and the legal ranges
// that the top level checks at elaboration time.
package gf180mcu_fd_sc_mcu9t5v0__sync_debounce_pkg;

  // Filter state as seen from the stability counter (STEADY when cnt == 0).
  typedef enum logic {
    STEADY  = 1'b0,
    PENDING = 1'b1
  } state_e;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int CNT_W_DEF         = 4;
  localparam int STABLE_CYCLES_DEF = 8;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int STABLE_CYCLES_MIN = 1;

  // Largest value a counter of the given width can hold.
  function automatic int cnt_limit(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_debounce_sync.sv
// Multi-flop synchroniser for an asynchronous level input. The reset value
// is a parameter so pad inputs that idle high can come out of reset quiet.
module gf180mcu_fd_sc_mcu9t5v0__sync_debounce_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rn_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain; bit 0 is the metastable catcher.
  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_debounce.sv
// Synchronising glitch filter feeding the downstream buf stage. A new level
// reaches Z only after STABLE_CYCLES consecutive synchronised samples that
// disagree with Z; EN=0 bypasses qualification but keeps the synchroniser.
// Optional build macro GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN adds
// registered one-cycle rise/fall pulses ZR/ZF aligned with the Z update.
module gf180mcu_fd_sc_mcu9t5v0__sync_debounce
  import gf180mcu_fd_sc_mcu9t5v0__sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int   CNT_W         = CNT_W_DEF,
  parameter int   STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic CLK,
  input  logic RN,
  input  logic I,
  input  logic EN,
  output logic Z,
  output logic BUSY
`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
  ,
  output logic ZR,
  output logic ZF
`endif
);

  // Counter value on which the next mismatching sample commits the change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (STABLE_CYCLES < STABLE_CYCLES_MIN || STABLE_CYCLES > cnt_limit(CNT_W)) begin : g_bad_stable
    $error("STABLE_CYCLES out of range for CNT_W");
  end

  logic             s;
  logic             z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  gf180mcu_fd_sc_mcu9t5v0__sync_debounce_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (RST_VAL)
  ) u_sync (
    .clk_i (CLK),
    .rn_i  (RN),
    .d_i   (I),
    .q_o   (s)
  );

  // Qualification: count uninterrupted mismatches, drop the run on any match.
  always_comb begin
    z_d   = z_q;
    cnt_d = cnt_q;
    if (!EN) begin
      z_d   = s;
      cnt_d = '0;
    end else if (s == z_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      z_d   = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Filter state registers; reset forces the output quiet immediately.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      z_q   <= RST_VAL;
      cnt_q <= '0;
    end else begin
      z_q   <= z_d;
      cnt_q <= cnt_d;
    end
  end

  assign Z    = z_q;
  assign BUSY = (cnt_q != '0);

`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
  logic zr_q, zf_q;

  // Edge pulses are registered with Z so they coincide with its first new cycle.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      zr_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      zr_q <= z_d & ~z_q;
      zf_q <= ~z_d & z_q;
    end
  end

  assign ZR = zr_q;
  assign ZF = zf_q;
`endif

  state_e state_w;
  assign state_w = (cnt_q != '0) ? PENDING : STEADY;

  a_cnt_bound: assert property (@(posedge CLK) disable iff (!RN) cnt_q <= CNT_LAST);
  a_bypass_steady: assert property (@(posedge CLK) disable iff (!RN) !EN |=> state_w == STEADY);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__sync_debounce.sv
// Directed bench for the synchronising debounce filter: one default-parameter
// instance and one STABLE_CYCLES=1 instance (edge pulses when built with
// GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN).
module tb_gf180mcu_fd_sc_mcu9t5v0__sync_debounce;

  logic clk;
  logic rn, i_in, en;
  logic z, busy;
  logic rn2, i2, en2;
  logic z2, busy2;
`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
  logic zr, zf, zr2, zf2;
`endif

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__sync_debounce dut (
    .CLK  (clk),
    .RN   (rn),
    .I    (i_in),
    .EN   (en),
    .Z    (z),
    .BUSY (busy)
`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
    ,
    .ZR   (zr),
    .ZF   (zf)
`endif
  );

  gf180mcu_fd_sc_mcu9t5v0__sync_debounce #(.STABLE_CYCLES(1)) dut1 (
    .CLK  (clk),
    .RN   (rn2),
    .I    (i2),
    .EN   (en2),
    .Z    (z2),
    .BUSY (busy2)
`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
    ,
    .ZR   (zr2),
    .ZF   (zf2)
`endif
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rn = 1'b0; i_in = 1'b1; en = 1'b1;
    rn2 = 1'b0; i2 = 1'b0; en2 = 1'b1;
    #2;
    chk("rst_z_async", z, 1'b0);
    chk("rst_busy_async", busy, 1'b0);
    tick(); tick();
    chk("rst_z_held", z, 1'b0);
    chk("rst_busy_held", busy, 1'b0);

    // Release with I=1 held: BUSY after edge 3..9, Z rises after edge 10.
    rn = 1'b1; rn2 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("rel_z_e%0d", k), z, (k >= 10));
      chk($sformatf("rel_busy_e%0d", k), busy, (k >= 3 && k <= 9));
    end

    // Bring Z back to 0.
    i_in = 1'b0;
    repeat (12) tick();
    chk("fall_z", z, 1'b0);
    chk("fall_busy", busy, 1'b0);

    // Glitch: 5-cycle pulse is rejected, BUSY high after edges 3..7.
    i_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5) i_in = 1'b0;
      chk($sformatf("gl_z_e%0d", k), z, 1'b0);
      chk($sformatf("gl_busy_e%0d", k), busy, (k >= 3 && k <= 7));
    end

    // Bounce: 3-cycle runs never qualify.
    for (int t = 0; t < 4; t++) begin
      i_in = (t % 2 == 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk($sformatf("bn_z_t%0d_%0d", t, k), z, 1'b0);
      end
    end
    i_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("bn_final_z_e%0d", k), z, (k >= 10));
    end

    // Bypass: Z follows s one edge late, BUSY stays low.
    en = 1'b0; i_in = 1'b0;
    repeat (4) tick();
    chk("byp_z_low", z, 1'b0);
    i_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("byp_z_e%0d", k), z, (k >= 3));
      chk($sformatf("byp_busy_e%0d", k), busy, 1'b0);
    end

    // EN 1->0 while cnt=4: pending count discarded, Z takes s.
    en = 1'b1; i_in = 1'b0;
    repeat (6) tick();
    chk("en10_busy_pend", busy, 1'b1);
    chk("en10_z_pend", z, 1'b1);
    en = 1'b0;
    tick();
    chk("en10_z_taken", z, 1'b0);
    chk("en10_busy_clr", busy, 1'b0);

    // EN 0->1: full qualification from zero.
    en = 1'b1; i_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("en01_z_e%0d", k), z, (k >= 10));
    end

    // Reset mid-PENDING (cnt=5), between edges.
    i_in = 1'b0;
    repeat (7) tick();
    chk("mid_busy_pend", busy, 1'b1);
    chk("mid_z_pend", z, 1'b1);
    #2 rn = 1'b0;
    #1;
    chk("mid_rst_z", z, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    i_in = 1'b1;
    tick();
    rn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("mid_requal_z_e%0d", k), z, (k >= 10));
      chk($sformatf("mid_requal_busy_e%0d", k), busy, (k >= 3 && k <= 9));
    end

    // STABLE_CYCLES=1 instance: Z one edge after s, BUSY never set.
    i2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("sc1_rise_z_e%0d", k), z2, (k >= 3));
      chk($sformatf("sc1_rise_busy_e%0d", k), busy2, 1'b0);
`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
      chk($sformatf("sc1_zr_e%0d", k), zr2, (k == 3));
      chk($sformatf("sc1_zf_r_e%0d", k), zf2, 1'b0);
`endif
    end
    i2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("sc1_fall_z_e%0d", k), z2, (k < 3));
`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
      chk($sformatf("sc1_zf_e%0d", k), zf2, (k == 3));
      chk($sformatf("sc1_zr_f_e%0d", k), zr2, 1'b0);
`endif
    end
    i2 = 1'b1;
    repeat (4) tick();
    chk("sc1_high_again", z2, 1'b1);
    #2 rn2 = 1'b0;
    #1;
    chk("sc1_rst_z", z2, 1'b0);
`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
    chk("sc1_rst_zf", zf2, 1'b0);
`endif
    tick(); tick();
    chk("sc1_rst_z_held", z2, 1'b0);
`ifdef GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE_EDGE_EN
    chk("sc1_rst_zf_held", zf2, 1'b0);
    chk("sc1_rst_zr_held", zr2, 1'b0);
    chk("dflt_zr_idle", zr, 1'b0);
    chk("dflt_zf_idle", zf, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
